// File: rtl/interrupt_arbiter_if.sv
// Bus between the interrupt arbiter and the CPU micro-sequencer / interrupt sources.
// The debug fields expose the arbiter FSM state and the latched NMI request.
interface interrupt_arbiter_if #(
  parameter int N_MI = 8
);
  // Handshake: INTREQ is a request level and IF the strobe that accepts it on the
  // same rising edge; int_ack is a one-cycle pulse answered by a one-cycle ack.
  logic            IF;
  logic            GIE;
  logic            int_ack;
  logic            nmi_src;
  logic [N_MI-1:0] mi_src;
  logic            rst_cpu;
  logic            INTREQ;
  logic [15:0]     vec;
  logic            nmi_ack;
  logic [N_MI-1:0] mi_ack;
  logic [1:0]      state_dbg;
  logic            nmi_pend_dbg;

  modport master (
    output IF, GIE, int_ack, nmi_src, mi_src,
    input  rst_cpu, INTREQ, vec, nmi_ack, mi_ack, state_dbg, nmi_pend_dbg
  );

  modport slave (
    input  IF, GIE, int_ack, nmi_src, mi_src,
    output rst_cpu, INTREQ, vec, nmi_ack, mi_ack, state_dbg, nmi_pend_dbg
  );
endinterface

// File: rtl/interrupt_arbiter.sv
// Reset/interrupt front-end: synchronises reset release, latches NMI edges, arbitrates
// a fixed-priority winner and holds its vector through the interrupt sequence.
module interrupt_arbiter #(
  parameter int          N_MI     = 8,
  parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
  input  logic                clk,
  input  logic                rst,
  interrupt_arbiter_if.slave  bus
);
  localparam int IW = (N_MI > 1) ? $clog2(N_MI) : 1;
  localparam logic [15:0] VEC_NMI   = 16'hFFFC;
  localparam logic [15:0] VEC_RESET = 16'hFFFE;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_IDLE   = 2'd1,
    S_LOCKED = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [N_MI-1:0] mi_q;
  logic            nmi_q;
  logic            nmi_pend_q, nmi_pend_d;
  logic            win_nmi_q;
  logic [IW-1:0]   win_id_q;
  logic [15:0]     vec_q;
  logic            nmi_ack_q;
  logic [N_MI-1:0] mi_ack_q;

  logic            rst_cpu;
  logic            intreq;
  logic [IW-1:0]   top_id;
  logic            lock;
  logic            ack_fire;
  logic            nmi_set;

  // Release side of the reset goes through two flops; assertion is immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], 1'b0};
  end

  // Highest set index wins among the maskable sources.
  always_comb begin
    top_id = '0;
    for (int i = 0; i < N_MI; i++) begin
      if (mi_q[i]) top_id = IW'(i);
    end
  end

  assign lock     = (state_q == S_IDLE) & intreq & bus.IF;
  assign ack_fire = (state_q == S_LOCKED) & bus.int_ack;
  assign nmi_set  = bus.nmi_src & ~nmi_q;

  // A new NMI edge on the acknowledge edge of the previous NMI must not be lost.
  always_comb begin
    nmi_pend_d = nmi_pend_q;
    if (ack_fire & win_nmi_q) nmi_pend_d = 1'b0;
    if (nmi_set)              nmi_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mi_q       <= '0;
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else if (state_q == S_RESET) begin
      mi_q       <= '0;
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      mi_q       <= bus.mi_src;
      nmi_q      <= bus.nmi_src;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_nmi_q <= 1'b0;
      win_id_q  <= '0;
      vec_q     <= VEC_RESET;
    end else if (lock) begin
      win_nmi_q <= nmi_pend_q;
      win_id_q  <= top_id;
      vec_q     <= nmi_pend_q ? VEC_NMI : (VEC_BASE + (16'(top_id) << 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_ack_q <= 1'b0;
      mi_ack_q  <= '0;
    end else begin
      nmi_ack_q <= ack_fire & win_nmi_q;
      mi_ack_q  <= (ack_fire & ~win_nmi_q) ? (N_MI'(1) << win_id_q) : '0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // FSM: next state. RESET leaves on the same edge that clears rst_cpu.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  if (!sync_q[0])   state_d = S_IDLE;
      S_IDLE:   if (lock)         state_d = S_LOCKED;
      S_LOCKED: if (bus.int_ack)  state_d = S_HOLD;
      S_HOLD:                     state_d = S_IDLE;
      default:                    state_d = S_RESET;
    endcase
  end

  // FSM: outputs. INTREQ is combinational so the CAR logic sees it alongside IF.
  always_comb begin
    rst_cpu          = sync_q[1];
    intreq           = (state_q == S_IDLE) & ~rst_cpu &
                       (nmi_pend_q | (bus.GIE & (|mi_q)));
    bus.rst_cpu      = rst_cpu;
    bus.INTREQ       = intreq;
    bus.vec          = vec_q;
    bus.nmi_ack      = nmi_ack_q;
    bus.mi_ack       = mi_ack_q;
    bus.state_dbg    = state_q;
    bus.nmi_pend_dbg = nmi_pend_q;
  end
endmodule

// File: doc/interrupt_arbiter.md
# interrupt_arbiter

Interrupt and reset front-end for the CPU micro-sequencer. It synchronises the external reset, latches NMI edges and samples maskable requests. It arbitrates a single winner by fixed priority and drives the `rst` and `INTREQ` inputs of the CAR next-address logic, together with the 16-bit vector address the interrupt uSeq fetches. It holds the winning vector stable through the interrupt sequence and returns a one-cycle acknowledge to the serviced source.

## Interface
- `N_MI`, 8: number of maskable sources. Legal range is 1..13.
- `VEC_BASE`, 16'hFFE0: vector address of `mi_src[0]`. `mi_src[i]` uses `VEC_BASE + 2*i`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-high.
- `IF`  in  1  instruction-fetch strobe from the control unit.
- `GIE`  in  1  status-register global interrupt enable.
- `int_ack`  in  1  one-cycle pulse from the interrupt uSeq when it reads the vector.
- `nmi_src`  in  1  non-maskable request; rising-edge sensitive.
- `mi_src`  in  N_MI  maskable requests; level sensitive. A higher index has higher priority.
- `rst_cpu`  out  1  reset request to the CAR logic; selects the no-push interrupt sequence.
- `INTREQ`  out  1  interrupt request to the CAR logic; selects the push interrupt sequence when combined with `IF`.
- `vec`  out  16  vector address for the current or last serviced event.
- `nmi_ack`  out  1  one-cycle acknowledge for the NMI.
- `mi_ack`  out  N_MI  one-hot, one-cycle acknowledge for the serviced maskable source.

## Operation
- States: RESET, IDLE, LOCKED, HOLD.
- Reset sync: `rst` asserts `rst_cpu` asynchronously. Release passes through a 2-flop synchroniser, and `rst_cpu` falls on the 2nd rising edge after `rst` falls. RESET moves to IDLE on that same edge.
- Input registers:
  - `mi_q` is `mi_src` registered once.
  - `nmi_q` is `nmi_src` registered once.
  - `nmi_pend` sets on `nmi_src & ~nmi_q` and clears on acknowledge of the NMI. If set and clear occur on the same edge, set wins.
- Request: `INTREQ = (state==IDLE) & ~rst_cpu & (nmi_pend | (GIE & |mi_q))`. This output is combinational, so the CAR logic sees it in the same cycle as `IF`.
- Priority: reset, then NMI, then `mi_q[N_MI-1]`, down to `mi_q[0]`. Maskable sources are considered only when `GIE`=1.
- Lock: on an edge where IDLE & `INTREQ` & `IF`:
  - latch the winner ID and `vec`, where NMI gives 16'hFFFC and MI i gives `VEC_BASE+2*i`;
  - move to LOCKED.
- LOCKED:
  - `INTREQ`=0; `vec` and the winner are frozen.
  - `IF` is ignored.
  - Source changes are ignored. A dropped MI is still serviced and acknowledged.
  - On `int_ack`, pulse the winner's ack for exactly the next cycle, clear `nmi_pend` if the winner is NMI, and move to HOLD.
- HOLD: lasts one cycle with `INTREQ`=0 so the SR/GIE update by the uSeq settles. Then move to IDLE.
- `int_ack` outside LOCKED is ignored.
- Vector arithmetic is a 16-bit add. `N_MI` ≤ 13 keeps vectors below 16'hFFFC.

## Timing
- Values while `rst` is high or in RESET:
  - `rst_cpu`=1, `INTREQ`=0, `vec`=16'hFFFE;
  - `nmi_ack`=0, `mi_ack`=0;
  - `nmi_pend`=0, `mi_q`=0, `nmi_q`=0.
- `vec` keeps 16'hFFFE until the first lock.
- Request latency: a source edge at edge N gives `INTREQ` high in cycle N+1. This requires IDLE, plus `GIE` for maskable sources.
- Lock takes 1 edge. The ack is registered and high in the cycle after the `int_ack` edge. IDLE returns 2 edges after the `int_ack` edge.
- Minimum spacing between two locks is 3 edges after `int_ack`.
- `GIE` is sampled combinationally. `GIE` falling while IDLE withdraws a maskable-only `INTREQ` in the same cycle.
- Reset in any state aborts immediately: no ack is issued, and a pending NMI is lost.

## Test plan
- Reset: hold `rst` for 3 cycles, then release. Expect `rst_cpu`=1 throughout, falling exactly 2 edges after release. Expect `vec`=FFFE and `INTREQ`=0.
- Single MI: `N_MI`=8, `GIE`=1, `mi_src`=8'h08. Expect `INTREQ` after 1 cycle. Pulse `IF`; expect `vec`=FFE6 and `INTREQ`=0. Pulse `int_ack`; expect `mi_ack`=8'h08 for 1 cycle and IDLE 2 edges later.
- Priority: `mi_src`=8'h28, `GIE`=1, `IF`. Expect `vec`=FFEA. After ack with `mi_src` held at 8'h08, expect a second lock with `vec`=FFE6.
- Masking and NMI: `GIE`=0, `mi_src`=8'hFF. Expect `INTREQ`=0. Give `nmi_src` a rising edge; expect `INTREQ`=1. `IF` gives `vec`=FFFC. Ack gives `nmi_ack` for 1 cycle.
- NMI set/clear collision: a second `nmi_src` rising edge arrives on the `int_ack` edge of an NMI. Expect `nmi_pend` stays 1 and `INTREQ` reasserts after HOLD.
- Reset mid-operation: assert `rst` while LOCKED. Expect `rst_cpu`=1 immediately, `vec`=FFFE, no ack pulse, and a subsequent `int_ack` ignored.
